// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment capture and display-driver side.
// Holds the 5-bit character code width, the named codes that are not plain
// hex digits, and the capture FSM state encoding.
package seven_segment_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] char_code_t;

    localparam char_code_t CHAR_BLANK   = 5'd16;
    localparam char_code_t CHAR_H       = 5'd17;
    localparam char_code_t CHAR_L       = 5'd18;
    localparam char_code_t CHAR_P       = 5'd19;
    localparam char_code_t CHAR_U       = 5'd20;
    localparam char_code_t CHAR_DASH    = 5'd21;
    localparam char_code_t CHAR_UNKNOWN = 5'd31;

    // IDLE: no digit selected, SETTLE: one-hot select being qualified,
    // HOLD: digit accepted, waiting for the scan to move on
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } capture_state_e;

endpackage

// File: rtl/seven_segment_to_char.sv
// Combinational decoder from an active-high abcdefg segment pattern
// (a = bit 6) to a 5-bit character code. Hex digits map to 0..15, a few
// letters and symbols map to the named package codes, everything else is
// reported as unknown.
// Ports:
//   pattern_i  7-bit active-high segment pattern abcdefg
//   code_o     5-bit character code
module seven_segment_to_char
    import seven_segment_pkg::*;
(
    input  logic [6:0]        pattern_i,
    output logic [CODE_W-1:0] code_o
);

    // Full lookup; lowercase b and d are the conventional hex shapes
    always_comb begin
        code_o = CHAR_UNKNOWN;
        case (pattern_i)
            7'b1111110: code_o = 5'd0;
            7'b0110000: code_o = 5'd1;
            7'b1101101: code_o = 5'd2;
            7'b1111001: code_o = 5'd3;
            7'b0110011: code_o = 5'd4;
            7'b1011011: code_o = 5'd5;
            7'b1011111: code_o = 5'd6;
            7'b1110000: code_o = 5'd7;
            7'b1111111: code_o = 5'd8;
            7'b1111011: code_o = 5'd9;
            7'b1110111: code_o = 5'd10;
            7'b0011111: code_o = 5'd11;
            7'b1001110: code_o = 5'd12;
            7'b0111101: code_o = 5'd13;
            7'b1001111: code_o = 5'd14;
            7'b1000111: code_o = 5'd15;
            7'b0000000: code_o = CHAR_BLANK;
            7'b0110111: code_o = CHAR_H;
            7'b0001110: code_o = CHAR_L;
            7'b1100111: code_o = CHAR_P;
            7'b0111110: code_o = CHAR_U;
            7'b0000001: code_o = CHAR_DASH;
            default:    code_o = CHAR_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Captures the characters shown on a multiplexed, active-low seven-segment
// display by watching its segment and digit-select lines. Each digit must be
// stable for stable_cycles synchronised samples before it is accepted; once
// every digit position has been accepted the whole frame is published.
// Ports:
//   clk           single clock
//   reset_n       asynchronous active-low reset
//   abcdefgh      segment lines a..g, dp (active-low, a = bit 7)
//   digit         digit selects (active-low, bit 0 = rightmost)
//   char_flat     per-digit character codes, slot i at bits 5i+4..5i
//   dp_flat       per-digit decimal point, active-high
//   frame_valid   one-cycle pulse when a new frame is published
//   select_error  one-cycle pulse when several digits are selected at once
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int w_digit       = 4,
    parameter int stable_cycles = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                abcdefgh,
    input  logic [w_digit-1:0]        digit,
    output logic [CODE_W*w_digit-1:0] char_flat,
    output logic [w_digit-1:0]        dp_flat,
    output logic                      frame_valid,
    output logic                      select_error
);

    // Counter value on the cycle whose sample is the last one needed
    localparam logic [7:0] ACCEPT_AT = 8'(stable_cycles - 1);
    localparam int         SAMPLE_W  = w_digit + 8;

    logic [7:0]         segMeta_q, segSync_q;
    logic [w_digit-1:0] selMeta_q, selSync_q;
    logic [7:0]         seg;
    logic [w_digit-1:0] sel;

    capture_state_e            state_q, state_d;
    logic [7:0]                count_q, count_d;
    logic [w_digit-1:0]        mask_q, mask_d;
    logic [SAMPLE_W-1:0]       sampleLast_q;
    logic [CODE_W*w_digit-1:0] pendChar_q, pendChar_d;
    logic [w_digit-1:0]        pendDp_q, pendDp_d;
    logic [CODE_W*w_digit-1:0] charFlat_q;
    logic [w_digit-1:0]        dpFlat_q;
    logic                      frameValid_q, frameDone;
    logic                      selectError_q, selectError_d;
    logic [CODE_W-1:0]         segCode;
    logic                      multiSel, prevMulti, changed, accept;

    assign seg = ~segSync_q;
    assign sel = ~selSync_q;

    seven_segment_to_char u_decode (
        .pattern_i (seg[7:1]),
        .code_o    (segCode)
    );

    // Two-flop synchroniser; idles at all-ones, which is "nothing lit"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            segMeta_q <= '1;
            segSync_q <= '1;
            selMeta_q <= '1;
            selSync_q <= '1;
        end else begin
            segMeta_q <= abcdefgh;
            segSync_q <= segMeta_q;
            selMeta_q <= digit;
            selSync_q <= selMeta_q;
        end
    end

    // Next-state logic. The error pulse only fires on entry into a
    // multi-select so a held overlap reports once, not every cycle.
    always_comb begin
        multiSel      = !$onehot0(sel);
        prevMulti     = !$onehot0(sampleLast_q[SAMPLE_W-1:8]);
        changed       = ({sel, seg} != sampleLast_q);
        state_d       = state_q;
        count_d       = count_q;
        accept        = 1'b0;
        selectError_d = 1'b0;
        if (multiSel) begin
            state_d       = IDLE;
            count_d       = 8'd0;
            selectError_d = !prevMulti;
        end else if (sel == '0) begin
            state_d = IDLE;
            count_d = 8'd0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (changed) begin
                        count_d = 8'd1;
                    end else begin
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        if (count_q >= ACCEPT_AT) begin
                            state_d = HOLD;
                            accept  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_d = SETTLE;
                        count_d = 8'd1;
                    end else begin
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    end
                end
                default: begin
                    state_d = SETTLE;
                    count_d = 8'd1;
                end
            endcase
        end
    end

    // Pending-frame update: accepted digit lands in its slot, and a full
    // mask publishes the merged data and starts a fresh mask
    always_comb begin
        pendChar_d = pendChar_q;
        pendDp_d   = pendDp_q;
        mask_d     = mask_q;
        frameDone  = 1'b0;
        if (accept) begin
            for (int i = 0; i < w_digit; i++) begin
                if (sel[i]) begin
                    pendChar_d[i*CODE_W +: CODE_W] = segCode;
                    pendDp_d[i]                    = seg[0];
                end
            end
            mask_d = mask_q | sel;
            if (mask_d == '1) begin
                frameDone = 1'b1;
                mask_d    = '0;
            end
        end
    end

    // Capture FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= 8'd0;
            mask_q        <= '0;
            sampleLast_q  <= '0;
            pendChar_q    <= '0;
            pendDp_q      <= '0;
            charFlat_q    <= '0;
            dpFlat_q      <= '0;
            frameValid_q  <= 1'b0;
            selectError_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            mask_q        <= mask_d;
            sampleLast_q  <= {sel, seg};
            pendChar_q    <= pendChar_d;
            pendDp_q      <= pendDp_d;
            frameValid_q  <= frameDone;
            selectError_q <= selectError_d;
            if (frameDone) begin
                charFlat_q <= pendChar_d;
                dpFlat_q   <= pendDp_d;
            end
        end
    end

    assign char_flat    = charFlat_q;
    assign dp_flat      = dpFlat_q;
    assign frame_valid  = frameValid_q;
    assign select_error = selectError_q;

endmodule
